shd_seq: RTL and testbench

Multi-cycle sequencer that executes SH-2A style dynamic shifts (SHAD/SHLD, shift by a register amount) by issuing a series of fixed-distance EXU_SHIFT operations to the execution unit's shifter. It sits beside the execution unit in the J22 core and owns the shift accumulator. For each shift step it selects a SHIFT_op code and feeds back the shifter result. The sequencer handles the decode stall and reports completion with a one-cycle done pulse.

---
 rtl/shd_seq.sv | 152 +++++++++++++++
 tb/tb_shd_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shd_seq.sv
// shd_seq: dynamic-shift (SHAD/SHLD) sequencer. It breaks a register-amount
// shift into fixed-distance EXU_SHIFT steps and owns the shift accumulator.
// Latency: steps + 1 cycles from the accept edge to done (1 for a zero count),
//          plus one cycle for every stalled RUN cycle.
// Backpressure: req_ready is low while RUN; stall holds the current step; done
//               has no backpressure.
// Ports: clk/rst (async, active-low); stall, abort; req_valid/req_ready with
//        req_arith, req_cnt, req_data; shifter side sh_issue, sh_ra, sh_code,
//        sh_rslt; status busy; result done/done_data.
// Optional feature: define SHIFT_SEQ_ABORT_EN to make the abort input kill an
// in-flight operation. Without it, abort is ignored.
module shd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        abort,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_arith,
   input  logic [31:0] req_cnt,
   input  logic [31:0] req_data,
   output logic        sh_issue,
   output logic [31:0] sh_ra,
   output logic [7:0]  sh_code,
   input  logic [31:0] sh_rslt,
   output logic        busy,
   output logic        done,
   output logic [31:0] done_data
);

   // SHIFT_op codes placed on rb[7:0]
   localparam logic [7:0] SHIFT_SHLL   = 8'h00;
   localparam logic [7:0] SHIFT_SHLL2  = 8'h01;
   localparam logic [7:0] SHIFT_SHLL8  = 8'h02;
   localparam logic [7:0] SHIFT_SHLL16 = 8'h03;
   localparam logic [7:0] SHIFT_SHLR   = 8'h04;
   localparam logic [7:0] SHIFT_SHLR2  = 8'h05;
   localparam logic [7:0] SHIFT_SHLR8  = 8'h06;
   localparam logic [7:0] SHIFT_SHLR16 = 8'h07;
   localparam logic [7:0] SHIFT_SHAR   = 8'h08;

   typedef enum logic {S_IDLE, S_RUN} state_t;
   typedef enum logic [1:0] {D_LEFT, D_RSHL, D_RSHA} dir_t;

   state_t      state_q, state_d;
   dir_t        dir_q, dir_d;
   logic [31:0] acc_q, acc_d;
   logic [5:0]  rem_q, rem_d;
   logic        done_q, done_d;

   logic [5:0]  chunk;
   logic [7:0]  step_code;
   logic [4:0]  neg_cnt;
   logic [5:0]  req_rem;
   logic        abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_hit = abort;
   logic unused_cnt_bits;
   assign unused_cnt_bits = ^req_cnt[30:5];
`else
   assign abort_hit = 1'b0;
   logic unused_cnt_bits;
   assign unused_cnt_bits = ^{req_cnt[30:5], abort};
`endif

   // Negative count: distance is the 5-bit magnitude, where 0 means 32.
   assign neg_cnt = (~req_cnt[4:0]) + 5'd1;
   assign req_rem = !req_cnt[31]      ? {1'b0, req_cnt[4:0]} :
                    (neg_cnt == 5'd0) ? 6'd32 : {1'b0, neg_cnt};

   // Largest fixed chunk not exceeding the remaining distance; the arithmetic
   // shifter only has a 1-bit form, so SHAR steps one bit at a time.
   always_comb begin
      chunk     = 6'd1;
      step_code = (dir_q == D_LEFT) ? SHIFT_SHLL : SHIFT_SHLR;
      if (dir_q == D_RSHA) begin
         chunk     = 6'd1;
         step_code = SHIFT_SHAR;
      end else if (rem_q >= 6'd16) begin
         chunk     = 6'd16;
         step_code = (dir_q == D_LEFT) ? SHIFT_SHLL16 : SHIFT_SHLR16;
      end else if (rem_q >= 6'd8) begin
         chunk     = 6'd8;
         step_code = (dir_q == D_LEFT) ? SHIFT_SHLL8 : SHIFT_SHLR8;
      end else if (rem_q >= 6'd2) begin
         chunk     = 6'd2;
         step_code = (dir_q == D_LEFT) ? SHIFT_SHLL2 : SHIFT_SHLR2;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !abort_hit) begin
               acc_d = req_data;
               rem_d = req_rem;
               if (!req_cnt[31])  dir_d = D_LEFT;
               else if (req_arith) dir_d = D_RSHA;
               else               dir_d = D_RSHL;
               if (req_rem == 6'd0) done_d  = 1'b1;
               else                 state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort_hit) begin
               // acc is deliberately left as-is on abort
               state_d = S_IDLE;
               rem_d   = 6'd0;
            end else if (!stall) begin
               acc_d = sh_rslt;
               rem_d = rem_q - chunk;
               if (rem_q == chunk) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dir_q   <= D_LEFT;
         acc_q   <= 32'd0;
         rem_q   <= 6'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign sh_issue  = (state_q == S_RUN);
   assign sh_code   = (state_q == S_RUN) ? step_code : SHIFT_SHLL;
   assign sh_ra     = acc_q;
   assign done      = done_q;
   assign done_data = acc_q;

endmodule

// File: tb/tb_shd_seq.sv
module tb_shd_seq;

   localparam logic [7:0] SHIFT_SHLL   = 8'h00;
   localparam logic [7:0] SHIFT_SHLL2  = 8'h01;
   localparam logic [7:0] SHIFT_SHLL8  = 8'h02;
   localparam logic [7:0] SHIFT_SHLL16 = 8'h03;
   localparam logic [7:0] SHIFT_SHLR   = 8'h04;
   localparam logic [7:0] SHIFT_SHLR2  = 8'h05;
   localparam logic [7:0] SHIFT_SHLR8  = 8'h06;
   localparam logic [7:0] SHIFT_SHLR16 = 8'h07;
   localparam logic [7:0] SHIFT_SHAR   = 8'h08;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        abort = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_arith = 1'b0;
   logic [31:0] req_cnt = 32'd0;
   logic [31:0] req_data = 32'd0;
   logic        sh_issue;
   logic [31:0] sh_ra;
   logic [7:0]  sh_code;
   logic [31:0] sh_rslt;
   logic        busy;
   logic        done;
   logic [31:0] done_data;

   int n_checks = 0;
   int n_errors = 0;

   shd_seq dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .abort     (abort),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_arith (req_arith),
      .req_cnt   (req_cnt),
      .req_data  (req_data),
      .sh_issue  (sh_issue),
      .sh_ra     (sh_ra),
      .sh_code   (sh_code),
      .sh_rslt   (sh_rslt),
      .busy      (busy),
      .done      (done),
      .done_data (done_data)
   );

   always #5 clk = ~clk;

   // Execution-unit shifter model
   function automatic logic [31:0] shifter(input logic [7:0] code, input logic [31:0] ra);
      logic signed [31:0] s;
      s = ra;
      case (code)
         SHIFT_SHLL:   return ra << 1;
         SHIFT_SHLL2:  return ra << 2;
         SHIFT_SHLL8:  return ra << 8;
         SHIFT_SHLL16: return ra << 16;
         SHIFT_SHLR:   return ra >> 1;
         SHIFT_SHLR2:  return ra >> 2;
         SHIFT_SHLR8:  return ra >> 8;
         SHIFT_SHLR16: return ra >> 16;
         SHIFT_SHAR:   return s >>> 1;
         default:      return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb sh_rslt = shifter(sh_code, sh_ra);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Shift distance of a request: 0..32
   function automatic int distance(input logic [31:0] cnt);
      logic [31:0] neg;
      if (!cnt[31]) return int'(cnt[4:0]);
      neg = -cnt;
      return (neg[4:0] == 5'd0) ? 32 : int'(neg[4:0]);
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [31:0] cnt,
                                              input logic arith);
      int n;
      logic signed [31:0] s;
      n = distance(cnt);
      s = d;
      if (!cnt[31]) return d << n;
      if (arith) return (n == 32) ? {32{d[31]}} : 32'(s >>> n);
      return (n == 32) ? 32'd0 : d >> n;
   endfunction

   function automatic int ref_steps(input logic [31:0] cnt, input logic arith);
      int n;
      n = distance(cnt);
      if (cnt[31] && arith) return n;
      return n / 16 + (n % 16) / 8 + (n % 8) / 2 + n % 2;
   endfunction

   // Code expected for the next step, given the remaining distance r
   function automatic logic [7:0] ref_code(input logic [31:0] cnt, input logic arith, input int r);
      logic left;
      left = !cnt[31];
      if (!left && arith) return SHIFT_SHAR;
      if (r >= 16) return left ? SHIFT_SHLL16 : SHIFT_SHLR16;
      if (r >= 8)  return left ? SHIFT_SHLL8  : SHIFT_SHLR8;
      if (r >= 2)  return left ? SHIFT_SHLL2  : SHIFT_SHLR2;
      return left ? SHIFT_SHLL : SHIFT_SHLR;
   endfunction

   function automatic int chunk_of(input logic [7:0] code);
      case (code)
         SHIFT_SHLL16, SHIFT_SHLR16: return 16;
         SHIFT_SHLL8,  SHIFT_SHLR8:  return 8;
         SHIFT_SHLL2,  SHIFT_SHLR2:  return 2;
         default:                    return 1;
      endcase
   endfunction

   // One request, from the accept cycle to the cycle after done.
   // stall_step/stall_len force a stall burst on a given (1-based) step.
   task automatic do_req(input string tag, input logic [31:0] d, input logic [31:0] cnt,
                         input logic arith, input int stall_pct,
                         input int stall_step, input int stall_len);
      int lat, steps, stalls, forced, r;
      logic prev_stalled;
      logic [7:0] prev_code, exp_code;
      @(negedge clk);
      check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_data  = d;
      req_cnt   = cnt;
      req_arith = arith;
      stall     = ($urandom_range(0, 1) == 1);  // no effect in IDLE
      @(negedge clk);
      req_valid = 1'b0;
      stall     = 1'b0;
      lat = 1; steps = 0; stalls = 0; forced = 0;
      r = distance(cnt);
      prev_stalled = 1'b0;
      prev_code = 8'h00;
      while (!done && lat < 200) begin
         check({tag, " issue"}, {31'd0, sh_issue}, 32'd1);
         exp_code = ref_code(cnt, arith, r);
         check({tag, " code"}, {24'd0, sh_code}, {24'd0, exp_code});
         if (prev_stalled) check({tag, " held"}, {24'd0, sh_code}, {24'd0, prev_code});
         prev_code = sh_code;
         if (steps + 1 == stall_step && forced < stall_len) begin
            stall = 1'b1;
            forced++;
         end else begin
            stall = ($urandom_range(0, 99) < stall_pct);
         end
`ifndef SHIFT_SEQ_ABORT_EN
         abort = ($urandom_range(0, 3) == 0);
`endif
         if (stall) stalls++;
         else begin
            steps++;
            r -= chunk_of(exp_code);
         end
         prev_stalled = stall;
         @(negedge clk);
         lat++;
      end
      stall = 1'b0;
      abort = 1'b0;
      check({tag, " done"}, {31'd0, done}, 32'd1);
      check({tag, " data"}, done_data, ref_result(d, cnt, arith));
      check({tag, " steps"}, steps, ref_steps(cnt, arith));
      check({tag, " lat"}, lat, ref_steps(cnt, arith) + 1 + stalls);
      check({tag, " rdy@done"}, {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      check({tag, " pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] c;
      rst = 1'b0;
      #22;
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst issue", {31'd0, sh_issue}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst ddata", done_data, 32'd0);
      check("rst code", {24'd0, sh_code}, {24'd0, SHIFT_SHLL});
      check("rst ra", sh_ra, 32'd0);
      rst = 1'b1;

      // Directed cases
      do_req("lsl5", 32'h1, 32'd5, 1'b0, 0, 0, 0);
      do_req("lsl31", 32'h1, 32'd31, 1'b0, 0, 0, 0);
      do_req("lsr32", 32'h8000_0000, 32'hFFFF_FFE0, 1'b0, 0, 0, 0);
      do_req("asr3", 32'h8000_0010, 32'hFFFF_FFFD, 1'b1, 0, 0, 0);
      do_req("stall", 32'h1, 32'd5, 1'b0, 0, 2, 2);
      do_req("zero", 32'h1234_5678, 32'd0, 1'b0, 0, 0, 0);
      do_req("asr32", 32'h8000_0001, 32'hFFFF_FFE0, 1'b1, 0, 0, 0);
      do_req("lsl32z", 32'hCAFE_F00D, 32'd32, 1'b1, 0, 0, 0);

      // Reset during RUN: immediate return to reset values, no done
      @(negedge clk);
      req_valid = 1'b1; req_data = 32'h8000_0000; req_cnt = 32'hFFFF_FFE0; req_arith = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst busy0", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      check("midrst ddata", done_data, 32'd0);
      check("midrst issue", {31'd0, sh_issue}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

`ifdef SHIFT_SEQ_ABORT_EN
      // Abort mid-RUN of a 32-step SHAD
      @(negedge clk);
      req_valid = 1'b1; req_data = 32'h8000_0000; req_cnt = 32'hFFFF_FFE0; req_arith = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("abort done2", {31'd0, done}, 32'd0);
      // Abort in IDLE blocks acceptance
      req_valid = 1'b1; req_cnt = 32'd5; req_data = 32'h1; req_arith = 1'b0; abort = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; abort = 1'b0;
      check("abort idle", {31'd0, busy}, 32'd0);
      do_req("post-abort", 32'h1, 32'd5, 1'b0, 0, 0, 0);
`endif

      // Randomized requests with random stalls
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: c = 32'($urandom_range(0, 31));
            1: c = -32'($urandom_range(1, 32));
            default: c = $urandom;
         endcase
         do_req("rand", $urandom, c, 1'($urandom_range(0, 1)), 25, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
